ehl_reverse_pipe: RTL

Registered, flow-controlled bit/group permutation unit. A per-beat mode selects pass-through, full bit reversal, group-order swap (byte swap when GROUP=8), or bit reversal within each group. The block sits on streaming datapaths (CRC/LSB-first serial interfaces, endianness conversion) between valid/ready producers and consumers. It sustains one beat per clock under back-pressure through a 2-entry skid buffer.

---
 rtl/ehl_reverse_pipe.sv | 83 ++++++++
 1 files changed

// File: rtl/ehl_reverse_pipe.sv
// Valid/ready bit and group permutation stage.
// The beat is permuted on entry and then held in an output register backed by one skid entry.
module ehl_reverse_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int N = WIDTH / GROUP;

  function automatic logic [WIDTH-1:0] permute(input logic [WIDTH-1:0] d,
                                               input logic [1:0]       mode);
    logic [WIDTH-1:0] r;
    r = d;
    case (mode)
      2'd1: begin
        for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
      end
      2'd2: begin
        for (int g = 0; g < N; g++)
          for (int b = 0; b < GROUP; b++)
            r[g*GROUP+b] = d[(N-1-g)*GROUP+b];
      end
      2'd3: begin
        for (int g = 0; g < N; g++)
          for (int b = 0; b < GROUP; b++)
            r[g*GROUP+b] = d[g*GROUP+GROUP-1-b];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] result_p0;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             accept;
  logic             transfer;

  // Stage p0: combinational permutation of the incoming beat
  assign result_p0 = permute(in_data, in_mode);

  // in_ready comes straight off the skid flop, so out_ready never reaches it combinationally
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign transfer = out_valid & out_ready;

  // Stage p1: output register with skid backup
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
    end else if (clr) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid && transfer) begin
      out_data   <= skid_data;
      out_valid  <= 1'b1;
      skid_valid <= 1'b0;
    end else if (accept && (!out_valid || transfer)) begin
      out_data  <= result_p0;
      out_valid <= 1'b1;
    end else if (accept) begin
      skid_data  <= result_p0;
      skid_valid <= 1'b1;
    end else if (transfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule
